// File: rtl/floo_pkg.sv
// Shared types, rule builders and FSM state encoding for the multicast mask unit.
package floo_pkg;

    localparam int unsigned DefAddrWidth   = 16;
    localparam int unsigned DimWidth       = 4;
    localparam int unsigned NumDimsDefault = 2;

    typedef logic [DefAddrWidth-1:0] addr_t;

    typedef struct packed {
        logic [1:0]          port_id;
        logic [DimWidth-1:0] z;
        logic [DimWidth-1:0] y;
        logic [DimWidth-1:0] x;
    } id_t;

    typedef struct packed {
        logic [4:0] offset;
        logic [4:0] len;
    } mask_sel_t;

    typedef struct packed {
        id_t                              idx;
        mask_sel_t [NumDimsDefault-1:0]   sel;
    } mask_rule_t;

    typedef enum logic [1:0] {
        MCAST_IDLE,
        MCAST_SEARCH,
        MCAST_RESP
    } mcast_mask_state_e;

    function automatic id_t mk_id(int unsigned x, int unsigned y, int unsigned z);
        id_t id;
        id         = '0;
        id.x       = x[DimWidth-1:0];
        id.y       = y[DimWidth-1:0];
        id.z       = z[DimWidth-1:0];
        return id;
    endfunction

    function automatic mask_sel_t mk_sel(int unsigned offset, int unsigned len);
        mask_sel_t s;
        s.offset = offset[4:0];
        s.len    = len[4:0];
        return s;
    endfunction

    function automatic mask_rule_t mk_rule(id_t idx, mask_sel_t sel_x, mask_sel_t sel_y);
        mask_rule_t r;
        r.idx    = idx;
        r.sel[0] = sel_x;
        r.sel[1] = sel_y;
        return r;
    endfunction

endpackage

// File: rtl/floo_mask_rule_search.sv
// Combinational compare of one RulesPerCycle-wide group of SAM rule IDs; lowest index wins.
module floo_mask_rule_search #(
    parameter int unsigned NumRules      = 1,
    parameter int unsigned RulesPerCycle = 1,
    parameter type         id_t          = floo_pkg::id_t,
    localparam int unsigned NumGrps      = (NumRules + RulesPerCycle - 1) / RulesPerCycle,
    localparam int unsigned GrpW         = (NumGrps > 1) ? $clog2(NumGrps) : 1,
    localparam int unsigned IdxW         = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  id_t [NumRules-1:0] i_rule_ids,
    input  logic [GrpW-1:0]    i_grp,
    input  id_t                i_id,
    output logic               o_hit,
    output logic [IdxW-1:0]    o_hit_idx
);

    id_t w_diff;

    // Rules outside the selected group are skipped, so a short last group never matches
    // past NumRules.
    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        o_hit     = 1'b0;
        o_hit_idx = '0;
        w_diff    = '0;
        for (int i = 0; i < int'(NumRules); i++) begin
            w_diff         = i_rule_ids[i] ^ i_id;
            w_diff.port_id = '0;
            if (!o_hit && (w_diff == '0) && (i_grp == GrpW'(i / int'(RulesPerCycle)))) begin
                o_hit     = 1'b1;
                o_hit_idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/floo_mcast_mask_unit.sv
// Handshaked multicast mask translator: multi-cycle SAM search, per-dimension mask extraction.
// Optional one-entry lookup cache enabled by FLOO_MCAST_MASK_CACHE_EN.
module floo_mcast_mask_unit
    import floo_pkg::*;
#(
    parameter int unsigned NumDims       = 2,
    parameter int unsigned NumRules      = 1,
    parameter int unsigned RulesPerCycle = 1,
    parameter type         id_t          = floo_pkg::id_t,
    parameter type         addr_t        = floo_pkg::addr_t,
    parameter type         mask_sel_t    = floo_pkg::mask_sel_t,
    parameter type         mask_rule_t   = floo_pkg::mask_rule_t,
    parameter mask_rule_t [NumRules-1:0] Sam = '0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  req_valid_i,
    output logic  req_ready_o,
    input  id_t   req_id_i,
    input  addr_t req_mask_i,
    output logic  rsp_valid_o,
    input  logic  rsp_ready_i,
    output id_t   rsp_mask_o,
    output logic  rsp_error_o,
    output logic  busy_o
);

    localparam int          AddrWidth = $bits(addr_t);
    localparam int unsigned NumGrps   = (NumRules + RulesPerCycle - 1) / RulesPerCycle;
    localparam int unsigned GrpW      = (NumGrps > 1) ? $clog2(NumGrps) : 1;
    localparam int unsigned IdxW      = (NumRules > 1) ? $clog2(NumRules) : 1;

    if (RulesPerCycle < 1 || RulesPerCycle > NumRules || NumDims < 1 || NumDims > 3) begin : g_param_check
        $error("floo_mcast_mask_unit: RulesPerCycle must be 1..NumRules and NumDims 1..3");
    end

    // Bits selected past the top of the address shift in as zero, which clips offset+len.
    function automatic logic [AddrWidth-1:0] extract(addr_t mask, mask_sel_t sel);
        logic [AddrWidth-1:0] v;
        v = mask >> sel.offset;
        for (int b = 0; b < AddrWidth; b++) begin
            if (b >= int'(sel.len)) v[b] = 1'b0;
        end
        return v;
    endfunction

    function automatic id_t build_mask(addr_t mask, mask_sel_t [NumDims-1:0] sel);
        id_t                  res;
        logic [AddrWidth-1:0] v;
        res = '0;
        for (int d = 0; d < int'(NumDims); d++) begin
            v = extract(mask, sel[d]);
            case (d)
                0:       res.x = v[$bits(res.x)-1:0];
                1:       res.y = v[$bits(res.y)-1:0];
                default: res.z = v[$bits(res.z)-1:0];
            endcase
        end
        return res;
    endfunction

    mcast_mask_state_e       r_state, w_state_next;
    id_t                     r_id;
    addr_t                   r_mask;
    logic [GrpW-1:0]         r_grp;
    id_t                     r_rsp_mask;
    logic                    r_rsp_error;
    id_t [NumRules-1:0]      w_rule_ids;
    logic                    w_hit;
    logic [IdxW-1:0]         w_hit_idx;
    logic                    w_last_grp;
    logic                    w_cache_hit;
    id_t                     w_cache_mask;

    for (genvar i = 0; i < NumRules; i++) begin : g_rule_ids
        assign w_rule_ids[i] = Sam[i].idx;
    end

    floo_mask_rule_search #(
        .NumRules      (NumRules),
        .RulesPerCycle (RulesPerCycle),
        .id_t          (id_t)
    ) u_search (
        .i_rule_ids (w_rule_ids),
        .i_grp      (r_grp),
        .i_id       (r_id),
        .o_hit      (w_hit),
        .o_hit_idx  (w_hit_idx)
    );

    assign w_last_grp = (r_grp == GrpW'(NumGrps - 1));

`ifdef FLOO_MCAST_MASK_CACHE_EN
    logic                      r_cache_valid;
    id_t                       r_cache_id;
    mask_sel_t [NumDims-1:0]   r_cache_sel;
    id_t                       w_cache_diff;

    always_comb begin
        w_cache_diff         = req_id_i ^ r_cache_id;
        w_cache_diff.port_id = '0;
    end

    assign w_cache_hit  = r_cache_valid && (w_cache_diff == '0);
    assign w_cache_mask = build_mask(req_mask_i, r_cache_sel);

    // Only successful searches fill the cache; error responses leave it untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cache_valid <= 1'b0;
            r_cache_id    <= '0;
            r_cache_sel   <= '0;
        end else if (r_state == MCAST_SEARCH && w_hit) begin
            r_cache_valid <= 1'b1;
            r_cache_id    <= r_id;
            r_cache_sel   <= Sam[w_hit_idx].sel;
        end
    end
`else
    assign w_cache_hit  = 1'b0;
    assign w_cache_mask = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= MCAST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            MCAST_IDLE:   if (req_valid_i) w_state_next = w_cache_hit ? MCAST_RESP : MCAST_SEARCH;
            MCAST_SEARCH: if (w_hit || w_last_grp) w_state_next = MCAST_RESP;
            MCAST_RESP:   if (rsp_ready_i) w_state_next = MCAST_IDLE;
            default:      w_state_next = MCAST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_id        <= '0;
            r_mask      <= '0;
            r_grp       <= '0;
            r_rsp_mask  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                MCAST_IDLE: begin
                    if (req_valid_i) begin
                        r_id   <= req_id_i;
                        r_mask <= req_mask_i;
                        r_grp  <= '0;
                        if (w_cache_hit) begin
                            r_rsp_mask  <= w_cache_mask;
                            r_rsp_error <= 1'b0;
                        end
                    end
                end
                MCAST_SEARCH: begin
                    if (w_hit) begin
                        r_rsp_mask  <= build_mask(r_mask, Sam[w_hit_idx].sel);
                        r_rsp_error <= 1'b0;
                    end else if (w_last_grp) begin
                        r_rsp_mask  <= '0;
                        r_rsp_error <= 1'b1;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (r_state == MCAST_IDLE);
    assign rsp_valid_o = (r_state == MCAST_RESP);
    assign busy_o      = (r_state != MCAST_IDLE);
    assign rsp_mask_o  = r_rsp_mask;
    assign rsp_error_o = r_rsp_error;

endmodule

// File: tb/tb_floo_mcast_mask_unit.sv
// Bench for floo_mcast_mask_unit: three search widths (1, 4, 3 rules/cycle) share one request
// stream and are compared against a rule-table model, including FLOO_MCAST_MASK_CACHE_EN builds.
module tb_floo_mcast_mask_unit;
    import floo_pkg::*;

`ifdef FLOO_MCAST_MASK_CACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    localparam int NumDuts = 3;
    localparam mask_rule_t [3:0] SAM = {
        mk_rule(mk_id(3, 1, 0), mk_sel(0, 4),  mk_sel(8, 4)),
        mk_rule(mk_id(3, 1, 0), mk_sel(4, 2),  mk_sel(6, 3)),
        mk_rule(mk_id(1, 2, 0), mk_sel(14, 4), mk_sel(0, 0)),
        mask_rule_t'(0)
    };

    // Reference rule table: id (x,y,z) and per-dimension {offset,len}.
    int m_x[4]  = '{0, 1, 3, 3};
    int m_y[4]  = '{0, 2, 1, 1};
    int m_z[4]  = '{0, 0, 0, 0};
    int m_xo[4] = '{0, 14, 4, 0};
    int m_xl[4] = '{0, 4, 2, 4};
    int m_yo[4] = '{0, 0, 6, 8};
    int m_yl[4] = '{0, 0, 3, 4};
    int rpc[NumDuts] = '{1, 4, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                req_valid;
    id_t                 req_id;
    addr_t               req_mask;
    logic [NumDuts-1:0]  rsp_ready, req_ready, rsp_valid, rsp_error, busy;
    id_t  [NumDuts-1:0]  rsp_mask;

    int n_checks = 0;
    int n_errors = 0;
    int hold[NumDuts];
    bit c_valid;
    int c_x, c_y, c_z;

    floo_mcast_mask_unit #(.NumDims(2), .NumRules(4), .RulesPerCycle(1), .Sam(SAM)) u_dut_rpc1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
        .req_id_i(req_id), .req_mask_i(req_mask), .rsp_valid_o(rsp_valid[0]),
        .rsp_ready_i(rsp_ready[0]), .rsp_mask_o(rsp_mask[0]), .rsp_error_o(rsp_error[0]),
        .busy_o(busy[0]));

    floo_mcast_mask_unit #(.NumDims(2), .NumRules(4), .RulesPerCycle(4), .Sam(SAM)) u_dut_rpc4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
        .req_id_i(req_id), .req_mask_i(req_mask), .rsp_valid_o(rsp_valid[1]),
        .rsp_ready_i(rsp_ready[1]), .rsp_mask_o(rsp_mask[1]), .rsp_error_o(rsp_error[1]),
        .busy_o(busy[1]));

    floo_mcast_mask_unit #(.NumDims(2), .NumRules(4), .RulesPerCycle(3), .Sam(SAM)) u_dut_rpc3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[2]),
        .req_id_i(req_id), .req_mask_i(req_mask), .rsp_valid_o(rsp_valid[2]),
        .rsp_ready_i(rsp_ready[2]), .rsp_mask_o(rsp_mask[2]), .rsp_error_o(rsp_error[2]),
        .busy_o(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_rule(input id_t id);
        for (int r = 0; r < 4; r++) begin
            if (int'(id.x) == m_x[r] && int'(id.y) == m_y[r] && int'(id.z) == m_z[r]) return r;
        end
        return -1;
    endfunction

    function automatic int field(input logic [15:0] m, input int off, input int len);
        return ((int'(m) >> off) & ((1 << len) - 1)) & 15;
    endfunction

    task automatic check_idle(input string tag);
        for (int j = 0; j < NumDuts; j++) begin
            check($sformatf("%s_ready%0d", tag, j), req_ready[j], 1'b1);
            check($sformatf("%s_busy%0d", tag, j), busy[j], 1'b0);
            check($sformatf("%s_valid%0d", tag, j), rsp_valid[j], 1'b0);
            check($sformatf("%s_mask%0d", tag, j), rsp_mask[j], '0);
            check($sformatf("%s_err%0d", tag, j), rsp_error[j], 1'b0);
        end
    endtask

    // Issue one request at a negedge and follow every DUT until its handshake completes.
    task automatic run_req(input id_t id, input logic [15:0] m);
        int  rule;
        int  exp_lat[NumDuts];
        int  vcnt[NumDuts];
        bit  seen[NumDuts];
        bit  done[NumDuts];
        bit  chit;
        bit  exp_err;
        id_t exp_mask;
        rule     = find_rule(id);
        chit     = CacheEn && c_valid && int'(id.x) == c_x && int'(id.y) == c_y && int'(id.z) == c_z;
        exp_err  = (rule < 0);
        exp_mask = '0;
        if (rule >= 0) begin
            exp_mask.x = 4'(field(m, m_xo[rule], m_xl[rule]));
            exp_mask.y = 4'(field(m, m_yo[rule], m_yl[rule]));
            c_valid = 1'b1;
            c_x = m_x[rule];
            c_y = m_y[rule];
            c_z = m_z[rule];
        end
        for (int j = 0; j < NumDuts; j++) begin
            if (chit)          exp_lat[j] = 1;
            else if (rule < 0) exp_lat[j] = (4 + rpc[j] - 1) / rpc[j] + 1;
            else               exp_lat[j] = rule / rpc[j] + 2;
            seen[j] = 1'b0;
            done[j] = 1'b0;
            vcnt[j] = 0;
            rsp_ready[j] = (hold[j] == 0);
            check($sformatf("accept_ready%0d", j), req_ready[j], 1'b1);
        end
        req_valid = 1'b1;
        req_id    = id;
        req_mask  = m;
        @(negedge clk);
        req_valid = 1'b0;
        req_id    = id_t'($urandom);
        req_mask  = addr_t'($urandom);
        for (int c = 1; c <= 40 && !(done[0] && done[1] && done[2]); c++) begin
            for (int j = 0; j < NumDuts; j++) begin
                if (!done[j]) begin
                    if (!seen[j]) begin
                        if (rsp_valid[j]) begin
                            seen[j] = 1'b1;
                            vcnt[j] = 1;
                            check($sformatf("latency%0d", j), c, exp_lat[j]);
                            check($sformatf("rsp_mask%0d", j), rsp_mask[j], exp_mask);
                            check($sformatf("rsp_err%0d", j), rsp_error[j], exp_err);
                            check($sformatf("resp_ready_low%0d", j), req_ready[j], 1'b0);
                        end else begin
                            check($sformatf("search_busy%0d", j), busy[j], 1'b1);
                            check($sformatf("search_ready_low%0d", j), req_ready[j], 1'b0);
                        end
                    end else if (rsp_valid[j]) begin
                        vcnt[j]++;
                        check($sformatf("hold_mask%0d", j), rsp_mask[j], exp_mask);
                        check($sformatf("hold_err%0d", j), rsp_error[j], exp_err);
                        check($sformatf("hold_ready_low%0d", j), req_ready[j], 1'b0);
                    end else begin
                        done[j] = 1'b1;
                        check($sformatf("valid_cycles%0d", j), vcnt[j], (hold[j] > 1) ? hold[j] : 1);
                        check($sformatf("back_idle_ready%0d", j), req_ready[j], 1'b1);
                        check($sformatf("back_idle_busy%0d", j), busy[j], 1'b0);
                    end
                    rsp_ready[j] = (vcnt[j] >= hold[j]);
                end
            end
            @(negedge clk);
        end
        for (int j = 0; j < NumDuts; j++) check($sformatf("completed%0d", j), done[j], 1'b1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = '1;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        c_valid = 1'b0;
    endtask

    initial begin
        id_t id;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_id    = '0;
        req_mask  = '0;
        rsp_ready = '1;
        c_valid   = 1'b0;
        c_x = 0; c_y = 0; c_z = 0;
        hold = '{0, 0, 0};

        do_reset();
        check_idle("reset");
        @(negedge clk);
        check_idle("post_reset");

        run_req(mk_id(3, 1, 0), 16'h01B0);
        run_req(mk_id(7, 7, 0), 16'hFFFF);
        run_req(mk_id(3, 1, 0), 16'h0040);
        hold = '{5, 2, 0};
        run_req(mk_id(1, 2, 0), 16'hC000);
        hold = '{0, 0, 0};

        // Reset in the middle of a search: the request is dropped without a response.
        req_valid = 1'b1;
        req_id    = mk_id(7, 7, 0);
        req_mask  = 16'h1234;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        c_valid = 1'b0;
        check_idle("mid_reset");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_rsp_after_reset", rsp_valid[0], 1'b0);
        end

        run_req(mk_id(3, 1, 0), 16'h01B0);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0:       id = mk_id(0, 0, 0);
                1:       id = mk_id(1, 2, 0);
                2:       id = mk_id(3, 1, 0);
                3:       id = mk_id($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
                default: id = mk_id(7, 7, $urandom_range(0, 15));
            endcase
            id.port_id = 2'($urandom);
            for (int j = 0; j < NumDuts; j++) hold[j] = $urandom_range(0, 3);
            run_req(id, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
